// File: rtl/whack_pkg.sv
// whack_pkg: shared state encoding, default timing and LFSR taps for the whack round controller
package whack_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    GAP   = 3'd2,
    SHOW  = 3'd3,
    OVER  = 3'd4
  } state_e;
  localparam int DEF_LIFE_CYCLES = 50000000;
  localparam int DEF_GAP_CYCLES = 12500000;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/target_lfsr.sv
// target_lfsr: 16-bit Galois LFSR (taps 16,14,13,11), exposing its low OUT_W bits
module target_lfsr
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int OUT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             advance,
  output logic [OUT_W-1:0] state
);
  logic [15:0] state_q, state_d;
  always_comb state_d = advance ? ({1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0)) : state_q;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state_q <= SEED;
    else state_q <= state_d;
  assign state = state_q[OUT_W-1:0];
endmodule

// File: rtl/whack_round_controller.sv
// whack_round_controller: runs a whack-a-mole round, lighting random targets and scoring
// hits and misses while the downstream countdown timer is enabled
module whack_round_controller
  import whack_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int TARGET_LIFE_CYCLES = DEF_LIFE_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int SCORE_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   startGame,
  input  logic [NUM_TARGETS-1:0] hitKeys,
  input  logic                   gameEnd,
  output logic                   enableCountdown,
  output logic                   scoreReset,
  output logic [NUM_TARGETS-1:0] activeTarget,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SCORE_WIDTH-1:0] misses,
  output logic                   gameOver
);
  localparam int TW = $clog2(NUM_TARGETS);
  localparam int LW = $clog2(TARGET_LIFE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [LW-1:0]          life_q, life_d;
  logic [TW-1:0]          tgt_q, tgt_d, raw, pick, lfsr;
  logic                   has_prev_q, has_prev_d;
  logic                   start_q;
  logic [NUM_TARGETS-1:0] keys_q, key_rise, act_q, act_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d, misses_q, misses_d, score_inc, misses_inc;
  logic                   start_rise, en_q, en_d, srst_q, srst_d, gover_q, gover_d;

  target_lfsr #(.SEED(LFSR_SEED), .OUT_W(TW)) u_lfsr (
    .clock   (clock),
    .resetn  (resetn),
    .advance (state_q != IDLE),
    .state   (lfsr)
  );

  always_comb begin
    start_rise = startGame & ~start_q;
    key_rise = hitKeys & ~keys_q;
    raw = lfsr;
    // never relight the target that was just shown; wraps mod NUM_TARGETS
    pick = (has_prev_q && raw == tgt_q) ? raw + 1'b1 : raw;
    score_inc = &score_q ? score_q : score_q + 1'b1;
    misses_inc = &misses_q ? misses_q : misses_q + 1'b1;
    state_d = state_q;
    gap_d = gap_q;
    life_d = life_q;
    tgt_d = tgt_q;
    has_prev_d = has_prev_q;
    score_d = score_q;
    misses_d = misses_q;
    case (state_q)
      IDLE, OVER: if (start_rise) begin
        state_d = CLEAR;
        score_d = '0;
        misses_d = '0;
        has_prev_d = 1'b0;
      end
      CLEAR: begin
        state_d = GAP;
        gap_d = GW'(GAP_CYCLES - 1);
      end
      GAP:
        if (gameEnd) state_d = OVER;
        else if (gap_q == '0) begin
          state_d = SHOW;
          life_d = LW'(TARGET_LIFE_CYCLES - 1);
          tgt_d = pick;
          has_prev_d = 1'b1;
        end else gap_d = gap_q - 1'b1;
      SHOW:
        if (gameEnd) state_d = OVER;
        else if (key_rise[tgt_q]) begin
          state_d = GAP;
          gap_d = GW'(GAP_CYCLES - 1);
          score_d = score_inc;
        end else if (life_q == '0) begin
          state_d = GAP;
          gap_d = GW'(GAP_CYCLES - 1);
          misses_d = misses_inc;
        end else begin
          life_d = life_q - 1'b1;
          misses_d = |(key_rise & ~(NUM_TARGETS'(1) << tgt_q)) ? misses_inc : misses_q;
        end
      default: state_d = IDLE;
    endcase
    en_d = state_d == GAP || state_d == SHOW;
    srst_d = state_d == CLEAR;
    act_d = state_d == SHOW ? NUM_TARGETS'(1) << tgt_d : '0;
    gover_d = state_d == OVER;
  end

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      gap_q <= '0;
      life_q <= '0;
      tgt_q <= '0;
      has_prev_q <= 1'b0;
      start_q <= 1'b0;
      keys_q <= '0;
      score_q <= '0;
      misses_q <= '0;
      en_q <= 1'b0;
      srst_q <= 1'b0;
      act_q <= '0;
      gover_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      life_q <= life_d;
      tgt_q <= tgt_d;
      has_prev_q <= has_prev_d;
      start_q <= startGame;
      keys_q <= hitKeys;
      score_q <= score_d;
      misses_q <= misses_d;
      en_q <= en_d;
      srst_q <= srst_d;
      act_q <= act_d;
      gover_q <= gover_d;
    end

  assign enableCountdown = en_q;
  assign scoreReset = srst_q;
  assign activeTarget = act_q;
  assign score = score_q;
  assign misses = misses_q;
  assign gameOver = gover_q;
endmodule

// File: tb/tb_whack_round_controller.sv
// tb_whack_round_controller: directed and randomized checks of the round controller against a
// game-level reference model
module tb_whack_round_controller;
  localparam int N = 4;
  localparam int LIFE = 20;
  localparam int GAPC = 5;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_GAP = 2, M_SHOW = 3, M_OVER = 4;

  logic clock = 0, resetn = 0, startGame = 0, gameEnd = 0;
  logic [N-1:0] hitKeys = '0;
  logic enableCountdown, scoreReset, gameOver;
  logic [N-1:0] activeTarget, last_act;
  logic [7:0] score, misses, score_before;

  int vectors = 0, fails = 0;
  int m_st, m_gap, m_life, m_tgt, m_prev, m_score, m_miss;
  logic [15:0] m_lfsr;
  logic m_ps;
  logic [N-1:0] m_pk;

  whack_round_controller #(
    .NUM_TARGETS(N), .TARGET_LIFE_CYCLES(LIFE), .GAP_CYCLES(GAPC), .SCORE_WIDTH(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .resetn(resetn), .startGame(startGame), .hitKeys(hitKeys), .gameEnd(gameEnd),
    .enableCountdown(enableCountdown), .scoreReset(scoreReset), .activeTarget(activeTarget),
    .score(score), .misses(misses), .gameOver(gameOver)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_gap = 0; m_life = 0; m_tgt = 0; m_prev = -1;
    m_score = 0; m_miss = 0; m_lfsr = 16'hACE1; m_ps = 0; m_pk = '0;
  endtask

  task automatic model_step(input logic s, input logic [N-1:0] k, input logic g);
    logic srise;
    logic [N-1:0] kr;
    logic [15:0] l_old;
    int i;
    srise = s & ~m_ps;
    kr = k & ~m_pk;
    m_ps = s;
    m_pk = k;
    l_old = m_lfsr;
    if (m_st != M_IDLE) m_lfsr = lfsr_next(m_lfsr);
    case (m_st)
      M_IDLE, M_OVER: if (srise) begin m_st = M_CLEAR; m_score = 0; m_miss = 0; m_prev = -1; end
      M_CLEAR: begin m_st = M_GAP; m_gap = GAPC - 1; end
      M_GAP:
        if (g) m_st = M_OVER;
        else if (m_gap == 0) begin
          i = int'(l_old) % N;
          if (i == m_prev) i = (i + 1) % N;
          m_tgt = i; m_prev = i; m_life = LIFE - 1; m_st = M_SHOW;
        end else m_gap--;
      default:
        if (g) m_st = M_OVER;
        else if (kr[m_tgt]) begin
          m_score = (m_score == 255) ? 255 : m_score + 1; m_st = M_GAP; m_gap = GAPC - 1;
        end else if (m_life == 0) begin
          m_miss = (m_miss == 255) ? 255 : m_miss + 1; m_st = M_GAP; m_gap = GAPC - 1;
        end else begin
          m_life--;
          if ((kr & ~(N'(1) << m_tgt)) != 0) m_miss = (m_miss == 255) ? 255 : m_miss + 1;
        end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("scoreReset", 32'(scoreReset), 32'(m_st == M_CLEAR));
    chk("enableCountdown", 32'(enableCountdown), 32'(m_st == M_GAP || m_st == M_SHOW));
    chk("gameOver", 32'(gameOver), 32'(m_st == M_OVER));
    chk("activeTarget", 32'(activeTarget), m_st == M_SHOW ? 32'd1 << m_tgt : 32'd0);
    chk("score", 32'(score), 32'(m_score));
    chk("misses", 32'(misses), 32'(m_miss));
  endtask

  task automatic step(input logic s, input logic [N-1:0] k, input logic g);
    startGame = s; hitKeys = k; gameEnd = g;
    @(posedge clock);
    if (resetn) model_step(s, k, g);
    #1;
    check_all();
  endtask

  task automatic wait_show();
    int n = 0;
    while (m_st != M_SHOW && n < 60) begin step(0, '0, 0); n++; end
    chk("wait_show_bound", 32'(n < 60), 32'd1);
  endtask

  task automatic hit_lit();
    wait_show();
    step(0, N'(1) << m_tgt, 0);
    step(0, '0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    resetn = 1;
    repeat (3) step(0, '0, 0);
    // start: one-cycle scoreReset, then countdown enabled, target after the gap
    step(1, '0, 0);
    chk("t1_scoreReset_high", 32'(scoreReset), 32'd1);
    step(1, '0, 0);
    chk("t1_scoreReset_once", 32'(scoreReset), 32'd0);
    chk("t1_enable", 32'(enableCountdown), 32'd1);
    for (int i = 0; i < GAPC - 1; i++) begin
      step(0, '0, 0);
      chk("t1_gap_dark", 32'(activeTarget), 32'd0);
    end
    step(0, '0, 0);
    chk("t1_target_lit", 32'(activeTarget != '0), 32'd1);
    last_act = activeTarget;
    // three correct hits, 3 cycles into each SHOW
    for (int t = 0; t < 3; t++) begin
      wait_show();
      if (t > 0) chk("t2_no_repeat", 32'(activeTarget == last_act), 32'd0);
      last_act = activeTarget;
      step(0, '0, 0);
      step(0, '0, 0);
      step(0, N'(1) << m_tgt, 0);
      step(0, '0, 0);
    end
    chk("t2_score", 32'(score), 32'd3);
    chk("t2_misses", 32'(misses), 32'd0);
    // timeout miss followed by a full dark gap
    wait_show();
    repeat (LIFE) step(0, '0, 0);
    chk("t3_misses", 32'(misses), 32'd1);
    chk("t3_dark", 32'(activeTarget), 32'd0);
    for (int i = 0; i < GAPC - 1; i++) begin
      step(0, '0, 0);
      chk("t3_gap_dark", 32'(activeTarget), 32'd0);
    end
    step(0, '0, 0);
    chk("t3_relit", 32'(activeTarget != '0), 32'd1);
    // wrong key then right key
    wait_show();
    step(0, N'(1) << ((m_tgt + 1) % N), 0);
    step(0, '0, 0);
    step(0, N'(1) << m_tgt, 0);
    step(0, '0, 0);
    chk("t4_score", 32'(score), 32'd4);
    chk("t4_misses", 32'(misses), 32'd2);
    // random key activity
    for (int i = 0; i < 300; i++)
      step(0, ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0, 0);
    // drive score to saturation, then one more hit
    for (int i = 0; i < 300 && m_score < 255; i++) begin
      last_act = activeTarget;
      hit_lit();
    end
    chk("t4_reach_255", 32'(score), 32'd255);
    hit_lit();
    chk("t4_saturate", 32'(score), 32'd255);
    // gameEnd wins over a simultaneous correct hit
    wait_show();
    step(0, '0, 0);
    score_before = score;
    step(0, N'(1) << m_tgt, 1);
    chk("t5_score_held", 32'(score), 32'(score_before));
    chk("t5_gameOver", 32'(gameOver), 32'd1);
    chk("t5_enable_off", 32'(enableCountdown), 32'd0);
    chk("t5_dark", 32'(activeTarget), 32'd0);
    step(0, '0, 1);
    step(1, '0, 1);
    chk("t5_clear", 32'(scoreReset), 32'd1);
    step(0, '0, 1);
    chk("t5_gap_not_over", 32'(gameOver), 32'd0);
    chk("t5_gap_enable", 32'(enableCountdown), 32'd1);
    step(0, '0, 0);
    // async reset mid-SHOW with score 4
    repeat (4) hit_lit();
    wait_show();
    step(0, '0, 0);
    chk("t6_score4", 32'(score), 32'd4);
    #2;
    resetn = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    #2;
    resetn = 1;
    repeat (5) step(0, '0, 0);
    chk("t6_idle", 32'(enableCountdown), 32'd0);
    step(1, '0, 0);
    chk("t6_restart", 32'(scoreReset), 32'd1);
    step(0, '0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
